// File: rtl/ai_car_pkg.sv
// Shared types and constants for the AI traffic car spawn scheduler:
// screen coordinate type, lane x-position table and the scheduler FSM encoding.
package ai_car_pkg;

  typedef logic signed [10:0] coord_t;

  localparam coord_t SPAWN_Y_DEFAULT = -11'sd200;

  localparam logic [10:0] LANE_X [0:3] = '{11'd180, 11'd240, 11'd300, 11'd360};

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    PICK_LANE,
    ISSUE,
    COOLDOWN
  } spawn_state_t;

  // Lanes beyond the four-entry table continue the same 60-pixel pitch.
  function automatic logic [10:0] lane_x(input logic [2:0] lane);
    if (lane < 3'd4) return LANE_X[lane[1:0]];
    return 11'd180 + 11'd60 * 11'(lane);
  endfunction

endpackage

// File: rtl/lane_allocator.sv
// Lane occupancy and ownership: one-lane-per-cycle rotating free-lane probe, and lane
// release when the owning car goes inactive (release is applied before allocation).
module lane_allocator #(
  parameter int NUM_CARS  = 4,
  parameter int NUM_LANES = 4,
  localparam int CW = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1,
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
)(
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 clear,
  input  logic [NUM_CARS-1:0]  car_active,
  input  logic                 probe_load,
  input  logic [LW-1:0]        probe_start,
  input  logic                 probe_en,
  input  logic [CW-1:0]        alloc_car,
  input  logic                 drop_en,
  input  logic [CW-1:0]        drop_car,
  output logic [NUM_LANES-1:0] lane_busy,
  output logic [NUM_CARS-1:0]  car_has_lane,
  output logic [LW-1:0]        probe_lane,
  output logic                 probe_free,
  output logic                 probe_last
);

  logic [NUM_CARS-1:0]  active_q;
  logic [NUM_CARS-1:0]  fell;
  logic [CW-1:0]        owner [NUM_LANES];
  logic [NUM_LANES-1:0] busy_kept;
  logic [NUM_LANES-1:0] busy_nxt;
  logic [LW-1:0]        probe_cnt;

  assign fell       = active_q & ~car_active;
  assign probe_free = !busy_kept[probe_lane];
  assign probe_last = (probe_cnt == LW'(NUM_LANES - 1));

  always_comb begin
    busy_kept    = lane_busy;
    car_has_lane = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (fell[owner[l]] || (drop_en && owner[l] == drop_car)) busy_kept[l] = 1'b0;
      if (busy_kept[l]) car_has_lane[owner[l]] = 1'b1;
    end
    busy_nxt = busy_kept;
    if (probe_en && !busy_kept[probe_lane]) busy_nxt[probe_lane] = 1'b1;
  end

  // Activity history survives a game restart so a car falling right after it is still seen.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) active_q <= '0;
    else         active_q <= car_active;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      lane_busy  <= '0;
      probe_lane <= '0;
      probe_cnt  <= '0;
      for (int l = 0; l < NUM_LANES; l++) owner[l] <= '0;
    end else if (clear) begin
      lane_busy  <= '0;
      probe_lane <= '0;
      probe_cnt  <= '0;
      for (int l = 0; l < NUM_LANES; l++) owner[l] <= '0;
    end else begin
      lane_busy <= busy_nxt;
      if (probe_en && !busy_kept[probe_lane]) owner[probe_lane] <= alloc_car;
      if (probe_load) begin
        probe_lane <= probe_start;
        probe_cnt  <= '0;
      end else if (probe_en) begin
        probe_lane <= probe_lane + 1'b1;
        probe_cnt  <= probe_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ai_car_spawn_scheduler.sv
// Spawns AI cars: scans for a free car, allocates a lane, then holds spawn_valid/x/y
// until the car acks (or the ack timer expires); enforces a frame cooldown between spawns.
module ai_car_spawn_scheduler
  import ai_car_pkg::*;
#(
  parameter int     NUM_CARS         = 4,
  parameter int     NUM_LANES        = 4,
  parameter int     SPAWN_GAP_FRAMES = 30,
  parameter int     ACK_TIMEOUT      = 64,
  parameter coord_t SPAWN_Y          = SPAWN_Y_DEFAULT
)(
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 frame_start,
  input  logic                 game_running,
  input  logic                 game_restart,
  input  logic [10:0]          random,
  input  logic [NUM_CARS-1:0]  car_active,
  input  logic [NUM_CARS-1:0]  spawn_ack,
  output logic [NUM_CARS-1:0]  spawn_valid,
  output logic [10:0]          spawn_x,
  output coord_t               spawn_y,
  output logic [NUM_LANES-1:0] lane_busy,
  output logic [15:0]          spawn_count
);

  localparam int CW  = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;
  localparam int LW  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int CDW = $clog2(SPAWN_GAP_FRAMES + 1);
  localparam int TW  = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0]  LAST_CAR  = CW'(NUM_CARS - 1);
  localparam logic [CDW-1:0] GAP       = CDW'(SPAWN_GAP_FRAMES);
  localparam logic [TW-1:0]  LAST_WAIT = TW'(ACK_TIMEOUT - 1);

  spawn_state_t        state, state_nxt;
  logic [CW-1:0]       car_idx, sel_car;
  logic [CDW-1:0]      cooldown;
  logic [TW-1:0]       ack_timer;
  logic [NUM_CARS-1:0] car_has_lane;
  logic [LW-1:0]       probe_lane;
  logic                probe_free, probe_last;
  logic                scan_hit, probe_en, alloc, acked, timed_out;
  logic                unused_random;

  assign spawn_y       = SPAWN_Y;
  assign unused_random = ^random[10:LW];

  always_comb begin
    state_nxt = state;
    scan_hit  = 1'b0;
    probe_en  = 1'b0;
    alloc     = 1'b0;
    acked     = 1'b0;
    timed_out = 1'b0;
    case (state)
      IDLE:
        if (frame_start && game_running && cooldown == '0) state_nxt = SCAN;
      SCAN: begin
        scan_hit = !car_active[car_idx] && !car_has_lane[car_idx];
        if (scan_hit)                  state_nxt = PICK_LANE;
        else if (car_idx == LAST_CAR)  state_nxt = IDLE;
      end
      PICK_LANE: begin
        probe_en = 1'b1;
        alloc    = probe_free;
        if (probe_free)      state_nxt = ISSUE;
        else if (probe_last) state_nxt = IDLE;
      end
      ISSUE: begin
        acked     = spawn_ack[sel_car];
        timed_out = !acked && (ack_timer == LAST_WAIT);
        if (acked)          state_nxt = COOLDOWN;
        else if (timed_out) state_nxt = IDLE;
      end
      COOLDOWN:
        if (cooldown == '0 || (frame_start && cooldown == CDW'(1))) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)           state <= IDLE;
    else if (game_restart) state <= IDLE;
    else                   state <= state_nxt;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      car_idx     <= '0;
      sel_car     <= '0;
      cooldown    <= '0;
      ack_timer   <= '0;
      spawn_valid <= '0;
      spawn_x     <= '0;
      spawn_count <= '0;
    end else if (game_restart) begin
      car_idx     <= '0;
      sel_car     <= '0;
      cooldown    <= GAP;
      ack_timer   <= '0;
      spawn_valid <= '0;
      spawn_count <= '0;
    end else begin
      car_idx   <= (state == SCAN) ? car_idx + 1'b1 : '0;
      ack_timer <= (state == ISSUE) ? ack_timer + 1'b1 : '0;
      if (scan_hit) sel_car <= car_idx;
      if (alloc) begin
        spawn_valid          <= '0;
        spawn_valid[sel_car] <= 1'b1;
        spawn_x              <= lane_x(3'(probe_lane));
      end
      if (acked || timed_out) spawn_valid <= '0;
      if (acked && spawn_count != 16'hFFFF) spawn_count <= spawn_count + 16'd1;
      // The frame counter runs in every state so a restart cooldown also expires.
      if (acked)                              cooldown <= GAP;
      else if (frame_start && cooldown != '0) cooldown <= cooldown - 1'b1;
    end
  end

  lane_allocator #(
    .NUM_CARS  (NUM_CARS),
    .NUM_LANES (NUM_LANES)
  ) u_lane_allocator (
    .clk          (clk),
    .resetN       (resetN),
    .clear        (game_restart),
    .car_active   (car_active),
    .probe_load   (scan_hit),
    .probe_start  (random[LW-1:0]),
    .probe_en     (probe_en),
    .alloc_car    (sel_car),
    .drop_en      (timed_out),
    .drop_car     (sel_car),
    .lane_busy    (lane_busy),
    .car_has_lane (car_has_lane),
    .probe_lane   (probe_lane),
    .probe_free   (probe_free),
    .probe_last   (probe_last)
  );

endmodule

// File: tb/tb_ai_car_spawn_scheduler.sv
// Bench for ai_car_spawn_scheduler: a slot/lane ownership model predicts each spawn
// (lowest free car, first free lane from the random start) and the frame cooldown.
module tb_ai_car_spawn_scheduler;

  localparam int NC  = 4;
  localparam int NL  = 4;
  localparam int GAP = 30;
  localparam int TMO = 64;

  logic               clk = 1'b0;
  logic               resetN, frame_start, game_running, game_restart;
  logic [10:0]        random;
  logic [NC-1:0]      car_active, spawn_ack, spawn_valid;
  logic [10:0]        spawn_x;
  logic signed [10:0] spawn_y;
  logic [NL-1:0]      lane_busy;
  logic [15:0]        spawn_count;

  int total = 0;
  int bad   = 0;
  int owner_m [NL];
  int count_m;
  int cd_m;
  int lane_x_m [NL] = '{180, 240, 300, 360};
  logic signed [10:0] exp_y = -11'sd200;

  always #5 clk = ~clk;

  ai_car_spawn_scheduler #(
    .NUM_CARS(NC), .NUM_LANES(NL), .SPAWN_GAP_FRAMES(GAP), .ACK_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .resetN(resetN), .frame_start(frame_start), .game_running(game_running),
    .game_restart(game_restart), .random(random), .car_active(car_active),
    .spawn_ack(spawn_ack), .spawn_valid(spawn_valid), .spawn_x(spawn_x),
    .spawn_y(spawn_y), .lane_busy(lane_busy), .spawn_count(spawn_count)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit owns(input int car);
    for (int l = 0; l < NL; l++) if (owner_m[l] == car) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int pick_car();
    for (int i = 0; i < NC; i++) if (!car_active[i] && !owns(i)) return i;
    return -1;
  endfunction

  function automatic int pick_lane(input int start);
    for (int k = 0; k < NL; k++) if (owner_m[(start + k) % NL] < 0) return (start + k) % NL;
    return -1;
  endfunction

  function automatic logic [NL-1:0] busy_m();
    logic [NL-1:0] b;
    b = '0;
    for (int l = 0; l < NL; l++) b[l] = (owner_m[l] >= 0);
    return b;
  endfunction

  task automatic model_clear();
    for (int l = 0; l < NL; l++) owner_m[l] = -1;
    count_m = 0;
  endtask

  // One frame: predicts whether an attempt happens and what it yields, then checks it.
  task automatic run_frame(input string tag, input bit do_ack);
    int car, lane, waited;
    logic [NC-1:0] exp_v, noise;
    car  = -1;
    lane = -1;
    if (cd_m > 0) cd_m--;
    else if (game_running) begin
      car = pick_car();
      if (car >= 0) lane = pick_lane(int'(random[1:0]));
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    waited = 0;
    while (spawn_valid == '0 && waited < 16) begin
      tick();
      waited++;
    end
    if (lane < 0) begin
      total++;
      if (spawn_valid !== '0) begin
        $display("FAIL %s no_spawn: spawn_valid=%b want 0000", tag, spawn_valid); bad++;
      end
      return;
    end
    exp_v = NC'(1 << car);
    total++;
    if (spawn_valid !== exp_v) begin
      $display("FAIL %s valid: got %b want %b", tag, spawn_valid, exp_v); bad++;
    end
    total++;
    if (spawn_x !== 11'(lane_x_m[lane])) begin
      $display("FAIL %s spawn_x: got %0d want %0d", tag, spawn_x, lane_x_m[lane]); bad++;
    end
    total++;
    if (spawn_y !== exp_y) begin
      $display("FAIL %s spawn_y: got %0d want %0d", tag, spawn_y, exp_y); bad++;
    end
    if (!do_ack) return;
    noise = ~exp_v & NC'($urandom);
    if (noise != '0) begin
      spawn_ack = noise;
      tick();
      spawn_ack = '0;
      total++;
      if (spawn_valid !== exp_v || spawn_x !== 11'(lane_x_m[lane])) begin
        $display("FAIL %s foreign_ack: valid=%b x=%0d want %b x=%0d", tag, spawn_valid,
                 spawn_x, exp_v, lane_x_m[lane]); bad++;
      end
    end
    spawn_ack = exp_v;
    tick();
    spawn_ack = '0;
    owner_m[lane] = car;
    if (count_m < 65535) count_m++;
    cd_m = GAP;
    total++;
    if (spawn_valid !== '0) begin
      $display("FAIL %s valid_after_ack: got %b want 0000", tag, spawn_valid); bad++;
    end
    total++;
    if (lane_busy !== busy_m()) begin
      $display("FAIL %s lane_busy: got %b want %b", tag, lane_busy, busy_m()); bad++;
    end
    total++;
    if (spawn_count !== 16'(count_m)) begin
      $display("FAIL %s spawn_count: got %0d want %0d", tag, spawn_count, count_m); bad++;
    end
  endtask

  task automatic set_active(input int car, input bit v);
    if (car_active[car] && !v)
      for (int l = 0; l < NL; l++) if (owner_m[l] == car) owner_m[l] = -1;
    car_active[car] = v;
    tick();
    tick();
    total++;
    if (lane_busy !== busy_m()) begin
      $display("FAIL release car%0d: lane_busy=%b want %b", car, lane_busy, busy_m()); bad++;
    end
  endtask

  task automatic cooldown_frames();
    for (int f = 0; f < GAP; f++) run_frame("cooldown", 1'b1);
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    repeat (3) tick();
    total++;
    if (spawn_valid !== '0) begin $display("FAIL reset valid: got %b want 0", spawn_valid); bad++; end
    total++;
    if (spawn_x !== '0) begin $display("FAIL reset spawn_x: got %0d want 0", spawn_x); bad++; end
    total++;
    if (spawn_y !== exp_y) begin $display("FAIL reset spawn_y: got %0d want -200", spawn_y); bad++; end
    total++;
    if (lane_busy !== '0) begin $display("FAIL reset lane_busy: got %b want 0", lane_busy); bad++; end
    total++;
    if (spawn_count !== '0) begin $display("FAIL reset count: got %0d want 0", spawn_count); bad++; end
    resetN = 1'b1;
    tick();
    model_clear();
    cd_m = 0;
  endtask

  task automatic test_first_spawn();
    game_running = 1'b1;
    random = 11'd2;
    run_frame("first_spawn", 1'b1);
  endtask

  task automatic test_cooldown();
    random = 11'($urandom);
    cooldown_frames();
    run_frame("after_cooldown", 1'b1);
  endtask

  task automatic test_fill_and_release();
    random = 11'($urandom);
    cooldown_frames();
    run_frame("fill_car2", 1'b1);
    random = 11'($urandom);
    cooldown_frames();
    run_frame("fill_car3", 1'b1);
    set_active(0, 1'b1);
    cooldown_frames();
    run_frame("all_busy", 1'b1);
    set_active(0, 1'b0);
    random = 11'($urandom);
    run_frame("respawn_freed", 1'b1);
  endtask

  task automatic test_not_running();
    game_running = 1'b0;
    cooldown_frames();
    run_frame("not_running", 1'b1);
    game_running = 1'b1;
    run_frame("running_all_busy", 1'b1);
    set_active(1, 1'b1);
    set_active(1, 1'b0);
    game_running = 1'b0;
    run_frame("not_running_free", 1'b1);
    game_running = 1'b1;
    run_frame("running_again", 1'b1);
  endtask

  task automatic do_restart(input string tag);
    game_restart = 1'b1;
    tick();
    game_restart = 1'b0;
    model_clear();
    cd_m = GAP;
    total++;
    if (spawn_valid !== '0) begin $display("FAIL %s valid: got %b want 0", tag, spawn_valid); bad++; end
    total++;
    if (lane_busy !== '0) begin $display("FAIL %s lane_busy: got %b want 0", tag, lane_busy); bad++; end
    total++;
    if (spawn_count !== '0) begin $display("FAIL %s count: got %0d want 0", tag, spawn_count); bad++; end
  endtask

  task automatic test_wrap();
    do_restart("restart_idle");
    random = 11'd3;
    cooldown_frames();
    run_frame("lane3", 1'b1);
    cooldown_frames();
    run_frame("wrap_lane0", 1'b1);
  endtask

  task automatic test_timeout();
    int n;
    random = 11'($urandom);
    cooldown_frames();
    run_frame("timeout_issue", 1'b0);
    n = 0;
    while (spawn_valid != '0 && n < 200) begin
      n++;
      tick();
    end
    total++;
    if (n != TMO) begin $display("FAIL timeout_len: valid held %0d cycles want %0d", n, TMO); bad++; end
    total++;
    if (lane_busy !== busy_m()) begin
      $display("FAIL timeout lane_busy: got %b want %b", lane_busy, busy_m()); bad++;
    end
    total++;
    if (spawn_count !== 16'(count_m)) begin
      $display("FAIL timeout count: got %0d want %0d", spawn_count, count_m); bad++;
    end
  endtask

  task automatic test_restart_in_issue();
    random = 11'($urandom);
    run_frame("restart_issue", 1'b0);
    repeat (3) tick();
    do_restart("restart_issue");
  endtask

  task automatic test_async_reset();
    cooldown_frames();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    #2 resetN = 1'b0;
    #1;
    total++;
    if (spawn_valid !== '0 || spawn_x !== '0 || spawn_y !== exp_y || lane_busy !== '0 ||
        spawn_count !== '0) begin
      $display("FAIL async_reset: valid=%b x=%0d y=%0d busy=%b count=%0d want 0 0 -200 0 0",
               spawn_valid, spawn_x, spawn_y, lane_busy, spawn_count); bad++;
    end
    tick();
    resetN = 1'b1;
    tick();
    model_clear();
    cd_m = 0;
    random = 11'($urandom);
    run_frame("after_async_reset", 1'b1);
  endtask

  initial begin
    frame_start  = 1'b0;
    game_running = 1'b0;
    game_restart = 1'b0;
    random       = '0;
    car_active   = '0;
    spawn_ack    = '0;
    resetN       = 1'b0;
    test_reset();
    test_first_spawn();
    test_cooldown();
    test_fill_and_release();
    test_not_running();
    test_wrap();
    test_timeout();
    test_restart_in_issue();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ai_car_spawn_scheduler.md
Name: ai_car_spawn_scheduler

Overview:
- Sequences (re)spawning of the AI traffic cars: picks a free car slot, allocates a unique lane, and hands the spawn position to that car over a valid/ack handshake.
- Enforces a minimum frame gap between spawns.
- Sits between the game-state logic / random generator and the per-car AI modules; car modules report their activity back.

Parameters:
- NUM_CARS, 4, number of AI car slots scheduled.
- NUM_LANES, 4, number of lanes; must be a power of 2, at most 8.
- SPAWN_GAP_FRAMES, 30, minimum frames between two successful spawns.
- ACK_TIMEOUT, 64, clock cycles to wait for spawn_ack before abandoning the spawn.
- SPAWN_Y, -200, signed 11-bit y given to spawned cars.

Ports:
- clk  in  1  pixel clock
- resetN  in  1  reset
- frame_start  in  1  one-cycle pulse per frame
- game_running  in  1  spawning enabled while high
- game_restart  in  1  synchronous clear pulse (game_states bit 0)
- random  in  11  free-running random value
- car_active  in  NUM_CARS  bit i high while car i is on screen
- spawn_ack  in  NUM_CARS  car i accepted its spawn
- spawn_valid  out  NUM_CARS  one-hot spawn request
- spawn_x  out  11  lane x for the requested car
- spawn_y  out  11 signed  equals SPAWN_Y
- lane_busy  out  NUM_LANES  lane occupancy vector
- spawn_count  out  16  successful spawns since reset/restart, saturating

Behaviour:
- Reset: resetN is asynchronous, active-low; clock is clk.
- Reset values: spawn_valid=0, spawn_x=0, spawn_y=SPAWN_Y, lane_busy=0, spawn_count=0.
- Reset internal state: FSM=IDLE, cooldown=0, all lane_owner entries invalid.
- FSM states: IDLE, SCAN, PICK_LANE, ISSUE, COOLDOWN.
- IDLE:
  - On frame_start with game_running=1 and cooldown=0 -> SCAN, car index=0.
  - A spawn attempt starts at most once per frame.
- SCAN:
  - One car index examined per cycle.
  - First i with car_active[i]=0 and no lane owned -> PICK_LANE.
  - After index NUM_CARS-1 with none found -> IDLE; worst case NUM_CARS cycles.
- PICK_LANE:
  - Start lane = random[log2(NUM_LANES)-1:0], captured on SCAN exit.
  - Probe one lane per cycle, modulo NUM_LANES wrap.
  - First lane with lane_busy=0 -> set lane_busy, record owner=i, load spawn_x from the lane table -> ISSUE.
  - All NUM_LANES lanes busy -> IDLE, no spawn.
- ISSUE:
  - spawn_valid[i]=1, with spawn_x/spawn_y held stable until acked.
  - spawn_ack[i] seen in a cycle -> spawn_valid deasserts the next cycle, spawn_count increments, cooldown=SPAWN_GAP_FRAMES -> COOLDOWN.
  - ACK_TIMEOUT cycles without ack -> drop valid, free the lane -> IDLE, no count.
  - spawn_ack on other bits is ignored.
- COOLDOWN:
  - cooldown decrements on each frame_start.
  - Reaching 0 -> IDLE.
  - Spawning resumes no earlier than the frame after expiry.
- Lane release:
  - A lane is freed when its owner car's car_active falls 1->0, detected via a registered copy of car_active.
  - Freeing is independent of FSM state.
  - Release and allocation of the same lane in the same cycle: release applies first, so allocation sees the lane free.
- game_running=0:
  - No new attempt is started.
  - An in-flight ISSUE completes normally.
  - cooldown still counts.
- game_restart (higher priority than everything except resetN):
  - Next cycle: FSM=IDLE, spawn_valid=0, all lanes free, owners cleared, spawn_count=0, cooldown=SPAWN_GAP_FRAMES.
- Arithmetic:
  - Lane index wraps modulo NUM_LANES.
  - spawn_count saturates at 16'hFFFF.
  - cooldown width is clog2(SPAWN_GAP_FRAMES+1).

Decomposition:
- Package ai_car_pkg:
  - LANE_X constant table {180,240,300,360}.
  - FSM state enum.
  - SPAWN_Y default.
  - Shared typedef for an 11-bit signed screen coordinate.
- Sub-module lane_allocator: holds lane_busy and lane_owner, performs the rotating free-lane probe and release-on-deactivate.
- The FSM, cooldown and handshake logic stay in the top module.

Test Plan:
- Reset, game_running=1, all car_active=0, random=2, frame_start -> spawn_valid=0001, spawn_x=300, spawn_y=-200; ack -> lane_busy=0100, spawn_count=1.
- After a spawn, pulse frame_start 29 times -> no new spawn_valid; 30th pulse returns to IDLE; 31st pulse starts the next spawn, spawn_valid=0010.
- lane_busy=1111 with car 3 inactive -> no spawn_valid; drop car 0 car_active -> its lane freed, next allowed frame spawns into it.
- random=3 with lane 3 busy -> wraps to lane 0, spawn_x=180.
- Withhold ack 64 cycles -> spawn_valid drops, lane freed, spawn_count unchanged.
- game_restart during ISSUE -> next cycle spawn_valid=0, lane_busy=0, spawn_count=0; asynchronous resetN mid-PICK_LANE -> all outputs at reset values.
